// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 4-bit select mux: steps the select at a programmable
// rate, samples each slot and delivers packed 16-bit frames over valid/ready.
module mux_scan_ctrl #(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        En,
    output logic [1:0]  Sel,
    input  logic [3:0]  Y,
    output logic [15:0] Frame,
    output logic        Frame_valid,
    input  logic        Frame_ready,
    output logic        Busy,
    output logic        Overrun,
    input  logic        Clr_ovr
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] presc_r, presc_next_s;
    logic [1:0]       sel_r, sel_next_s;
    logic [11:0]      shadow_r, shadow_next_s;
    logic [15:0]      frame_r, frame_next_s;
    logic             frame_valid_r, frame_valid_next_s;
    logic             overrun_r, overrun_next_s;
    logic             busy_r;
    logic             tick_s, done_s, slot_free_s, load_s, drop_s;

    // Next-state, prescaler, sampling and output-slot decisions.
    always_comb begin
        state_next_s       = state_r;
        presc_next_s       = presc_r;
        sel_next_s         = sel_r;
        shadow_next_s      = shadow_r;
        frame_next_s       = frame_r;
        frame_valid_next_s = frame_valid_r;
        overrun_next_s     = overrun_r;

        tick_s      = (state_r == SCAN) && (presc_r == TICK_LAST);
        done_s      = tick_s && (sel_r == 2'd3);
        slot_free_s = !frame_valid_r || Frame_ready;
        load_s      = done_s && slot_free_s;
        drop_s      = done_s && !slot_free_s;

        case (state_r)
            IDLE: begin
                presc_next_s = {CNT_W{1'b0}};
                sel_next_s   = 2'd0;
                if (En) begin
                    state_next_s = SCAN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SCAN: begin
                if (tick_s) begin
                    presc_next_s = {CNT_W{1'b0}};
                    sel_next_s   = sel_r + 2'd1;
                end else begin
                    presc_next_s = presc_r + CNT_W'(1);
                    sel_next_s   = sel_r;
                end
                // En is only honoured at frame boundaries so frames are never cut short.
                if (done_s && !En) begin
                    state_next_s = IDLE;
                    sel_next_s   = 2'd0;
                end else begin
                    state_next_s = SCAN;
                end
            end
            default: begin
                state_next_s = IDLE;
                presc_next_s = {CNT_W{1'b0}};
                sel_next_s   = 2'd0;
            end
        endcase

        if (tick_s) begin
            case (sel_r)
                2'd0:    shadow_next_s[3:0]  = Y;
                2'd1:    shadow_next_s[7:4]  = Y;
                2'd2:    shadow_next_s[11:8] = Y;
                default: shadow_next_s       = shadow_r;
            endcase
        end else begin
            shadow_next_s = shadow_r;
        end

        if (load_s) begin
            frame_next_s       = {Y, shadow_r};
            frame_valid_next_s = 1'b1;
        end else if (frame_valid_r && Frame_ready) begin
            frame_valid_next_s = 1'b0;
        end else begin
            frame_valid_next_s = frame_valid_r;
        end

        // A drop on the same edge as a clear leaves the flag set.
        if (drop_s) begin
            overrun_next_s = 1'b1;
        end else if (Clr_ovr) begin
            overrun_next_s = 1'b0;
        end else begin
            overrun_next_s = overrun_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            presc_r       <= {CNT_W{1'b0}};
            sel_r         <= 2'd0;
            shadow_r      <= 12'd0;
            frame_r       <= 16'd0;
            frame_valid_r <= 1'b0;
            overrun_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            presc_r       <= presc_next_s;
            sel_r         <= sel_next_s;
            shadow_r      <= shadow_next_s;
            frame_r       <= frame_next_s;
            frame_valid_r <= frame_valid_next_s;
            overrun_r     <= overrun_next_s;
            busy_r        <= (state_next_s == SCAN);
        end
    end

    assign Sel         = sel_r;
    assign Frame       = frame_r;
    assign Frame_valid = frame_valid_r;
    assign Busy        = busy_r;
    assign Overrun     = overrun_r;

endmodule
